// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter: FSM states and the
// latched memory command. The command field widths track the default port widths.
package mem_arb_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_BE_W   = MEM_DATA_W / 8;
    localparam int STARVE_W   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                  we;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
        logic [MEM_BE_W-1:0]   be;
    } mem_cmd_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data accesses.
// Data wins contested grants until STARVE_MAX consecutive wins force a fetch grant.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int DATA_W     = MEM_DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ireq,
    input  logic [ADDR_W-1:0]   iaddr,
    output logic [DATA_W-1:0]   irdata,
    output logic                ivalid,
    input  logic                dreq,
    input  logic                dwe,
    input  logic [ADDR_W-1:0]   daddr,
    input  logic [DATA_W-1:0]   dwdata,
    input  logic [DATA_W/8-1:0] dbe,
    output logic [DATA_W-1:0]   drdata,
    output logic                dvalid,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack
);

    localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(STARVE_MAX);

    arb_state_t          state, state_next;
    logic [STARVE_W-1:0] starve_cnt, starve_next;
    mem_cmd_t            cmd_q, cmd_next;

    // Valid/ready contract: a requester raises req with stable fields and holds
    // them until its valid pulse; memory holds mem_req until a one-cycle mem_ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            cmd_q      <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
            cmd_q      <= cmd_next;
        end
    end

    always_comb begin
        state_next  = state;
        starve_next = starve_cnt;
        cmd_next    = cmd_q;
        unique case (state)
            IDLE: begin
                if (dreq && !(ireq && starve_cnt == STARVE_LIMIT)) begin
                    state_next     = BUSY_D;
                    cmd_next.we    = dwe;
                    cmd_next.addr  = daddr;
                    cmd_next.wdata = dwdata;
                    cmd_next.be    = dbe;
                    if (ireq && starve_cnt != STARVE_LIMIT) begin
                        starve_next = starve_cnt + 1'b1;
                    end
                end else if (ireq) begin
                    state_next     = BUSY_I;
                    cmd_next.we    = 1'b0;
                    cmd_next.addr  = iaddr;
                    cmd_next.wdata = '0;
                    cmd_next.be    = '1;
                    starve_next    = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                // Returning to IDLE for one cycle lets requesters drop req after valid.
                if (mem_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem_req   = (state != IDLE);
    assign mem_we    = cmd_q.we;
    assign mem_addr  = cmd_q.addr;
    assign mem_wdata = cmd_q.wdata;
    assign mem_be    = cmd_q.be;

    assign ivalid = (state == BUSY_I) && mem_ack;
    assign dvalid = (state == BUSY_D) && mem_ack;
    assign irdata = mem_rdata;
    assign drdata = mem_rdata;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the pipelined core's instruction-fetch port and data (load/store) port.
- Data accesses have priority; an anti-starvation counter guarantees fetch progress.
- Sits between the core (PC/instr fetch side, DataAdr/WriteData/MemWrite/MemWriteSelect/ReadData side) and the memory model.
- Completion pulses to each port let the core derive its stalls.

Parameters:
- ADDR_W, 32, address width of both ports and memory.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- STARVE_MAX, 4, consecutive contested data wins before fetch is forced a grant (range 1..15).

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- ireq  in  1  fetch request; held with iaddr stable until ivalid
- iaddr  in  ADDR_W  fetch address (PC)
- irdata  out  DATA_W  fetched instruction, valid when ivalid=1
- ivalid  out  1  fetch completion pulse
- dreq  in  1  data request; held with fields stable until dvalid
- dwe  in  1  1=store, 0=load
- daddr  in  ADDR_W  data address
- dwdata  in  DATA_W  store data
- dbe  in  DATA_W/8  store byte enables
- drdata  out  DATA_W  load data, valid when dvalid=1
- dvalid  out  1  data completion pulse
- mem_req  out  1  memory request; held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_be  out  DATA_W/8  memory byte enables
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion, legal only while mem_req=1

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: state=IDLE, starve_cnt=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0.
- Reset outputs: ivalid=0, dvalid=0; irdata and drdata follow mem_rdata (don't-care).
- States: IDLE, BUSY_I, BUSY_D.
- IDLE grant rules:
  - Only dreq=1: latch data fields, go to BUSY_D.
  - Only ireq=1: latch iaddr, mem_we=0, mem_be=all ones, mem_wdata=0, go to BUSY_I.
  - Both: go to BUSY_I if starve_cnt==STARVE_MAX, else BUSY_D.
- BUSY_x: mem_req=1, mem_* outputs taken from the latched registers. Stay until mem_ack=1, then go to IDLE.
- Completion:
  - ivalid = (state==BUSY_I) & mem_ack, combinational; irdata = mem_rdata.
  - dvalid = (state==BUSY_D) & mem_ack, combinational; drdata = mem_rdata. dvalid also pulses for stores, where drdata is don't-care.
- Latency: one mandatory IDLE cycle after every ack, so the minimum transaction is 2 cycles (grant edge to ack cycle inclusive, memory acking on its first request cycle). Back-to-back throughput is one transaction per 2 cycles. This lets requesters drop or change req in the cycle after valid without being re-granted.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) on each IDLE grant to data while ireq=1.
  - Clears to 0 on any grant to fetch.
  - Unchanged otherwise.
- mem_ack while state==IDLE is ignored; no valid pulse is generated.
- Request fields changing during BUSY have no effect; latched values are used.
- Reset mid-transaction: next cycle is IDLE with mem_req=0. The in-flight transaction is abandoned with no valid pulse, and a late mem_ack is ignored.
- ireq/dreq deasserted mid-transaction (protocol violation): the transaction still completes and valid still pulses.

Decomposition:
- Shared package mem_arb_pkg holds:
  - typedef enum logic [1:0] arb_state_t {IDLE, BUSY_I, BUSY_D};
  - typedef struct mem_cmd_t {we, addr, wdata, be};
  - localparam for the byte-enable width.
- No sub-module. The starvation counter and the command latch are inline.

Test Plan:
- Lone fetch: ireq=1, iaddr=0x0000_0010, memory acks 2nd BUSY cycle with 0x0050_0093 -> mem_req high 2 cycles, mem_we=0, mem_be=4'hF, ivalid=1 with irdata=0x0050_0093, next cycle mem_req=0.
- Lone store: dreq=1, dwe=1, daddr=0x64, dwdata=0xDEAD_BEEF, dbe=4'b0011, ack on 1st cycle -> mem_we=1, mem_addr=0x64, mem_be=4'b0011, dvalid pulses once, 2-cycle total.
- Contention/priority: ireq=dreq=1 continuously, immediate acks, STARVE_MAX=4 -> grant sequence D,D,D,D,I,D,D,D,D,I; starve_cnt 0..4 then 0.
- Re-request after valid: dreq held high for two consecutive loads (addr 0x100 then 0x104) -> exactly one IDLE cycle between them, two dvalid pulses, mem_addr 0x100 then 0x104.
- Reset mid-op: reset asserted in BUSY_D before ack, mem_ack arrives the next cycle -> mem_req=0, dvalid stays 0, starve_cnt=0, state IDLE.
- Stray ack: mem_ack=1 in IDLE with no requests -> ivalid=dvalid=0, state stays IDLE.
